// File: rtl/sm_mul_pkg.sv
//==============================================================================
// Module      : sm_mul_pkg
// Description : Shared constants for the sign-magnitude sequential multiplier:
//               default operand/fraction widths and FSM state encodings.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package sm_mul_pkg;

    // Default magnitude width per operand and output fraction width
    localparam int c_dataWDefault = 10;
    localparam int c_fracWDefault = 9;

    // FSM state encodings
    localparam logic [1:0] c_stIdle = 2'd0;
    localparam logic [1:0] c_stBusy = 2'd1;
    localparam logic [1:0] c_stDone = 2'd2;

endpackage

`default_nettype wire

// File: rtl/sm_round_sat.sv
//==============================================================================
// Module      : sm_round_sat
// Description : Rescales an unsigned product magnitude by 2^-FRAC_W with
//               round-half-up on magnitude, saturates to DATA_W bits and
//               reattaches the sign (zero magnitude always gets sign 0).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sm_round_sat
    import sm_mul_pkg::*;
#(
    parameter int DATA_W = c_dataWDefault,
    parameter int FRAC_W = c_fracWDefault
) (
    input  logic [2*DATA_W-1:0] accum,
    input  logic                sign,
    output logic [DATA_W:0]     prodQ,
    output logic                sat
);

    localparam int ACC_W = 2 * DATA_W;

    // Half an output LSB; the sum cannot carry out because the largest
    // product leaves far more headroom than 2^(FRAC_W-1).
    localparam logic [ACC_W-1:0] c_half = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_W - 1);

    logic [ACC_W-1:0]  w_rounded;
    logic [ACC_W-1:0]  w_shifted;
    logic              w_over;
    logic [DATA_W-1:0] w_mag;

    // Round, rescale, clip and re-sign the magnitude
    always_comb begin
        w_rounded = accum + c_half;
        w_shifted = w_rounded >> FRAC_W;
        w_over    = |w_shifted[ACC_W-1:DATA_W];
        w_mag     = w_over ? {DATA_W{1'b1}} : w_shifted[DATA_W-1:0];
        prodQ     = {sign & (|w_mag), w_mag};
        sat       = w_over;
    end

endmodule

`default_nettype wire

// File: rtl/sm_seq_multiplier.sv
//==============================================================================
// Module      : sm_seq_multiplier
// Description : Sign-magnitude shift-and-add multiplier, one partial product
//               per clock, valid/ready handshakes on both sides, plus a
//               rounded and saturated rescaled output.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sm_seq_multiplier
    import sm_mul_pkg::*;
#(
    parameter int DATA_W = c_dataWDefault,
    parameter int FRAC_W = c_fracWDefault
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W:0]     a,
    input  logic [DATA_W:0]     b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*DATA_W:0]   prod,
    output logic [DATA_W:0]     prod_q,
    output logic                sat
);

    localparam int ACC_W = 2 * DATA_W;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] c_lastCnt = CNT_W'(DATA_W - 1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_magA;
    logic [DATA_W-1:0] r_magB;
    logic              r_sign;
    logic [ACC_W-1:0]  r_accum;
    logic              r_inReady;
    logic              r_outValid;
    logic [ACC_W:0]    r_prod;
    logic [DATA_W:0]   r_prodQ;
    logic              r_sat;

    logic              w_accept;
    logic              w_release;
    logic [ACC_W-1:0]  w_partial;
    logic [ACC_W-1:0]  w_accNext;
    logic              w_lastBit;
    logic [DATA_W:0]   w_prodQ;
    logic              w_sat;

    // Handshakes and the accumulator value after this cycle's partial product
    always_comb begin
        w_accept  = in_valid & r_inReady;
        w_release = r_outValid & out_ready;
        w_partial = r_magB[r_cnt] ? ({{DATA_W{1'b0}}, r_magA} << r_cnt) : '0;
        w_accNext = r_accum + w_partial;
        w_lastBit = (r_cnt == c_lastCnt);
    end

    // Rescaled view of the final accumulator, captured on the BUSY-to-DONE edge
    sm_round_sat #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_roundSat (
        .accum (w_accNext),
        .sign  (r_sign),
        .prodQ (w_prodQ),
        .sat   (w_sat)
    );

    // Control FSM with datapath registers; flush outranks both handshakes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_stIdle;
            r_cnt      <= '0;
            r_magA     <= '0;
            r_magB     <= '0;
            r_sign     <= 1'b0;
            r_accum    <= '0;
            r_inReady  <= 1'b0;
            r_outValid <= 1'b0;
            r_prod     <= '0;
            r_prodQ    <= '0;
            r_sat      <= 1'b0;
        end else if (flush) begin
            r_state    <= c_stIdle;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
        end else begin
            case (r_state)
                c_stIdle: begin
                    if (w_accept) begin
                        r_magA    <= a[DATA_W-1:0];
                        r_magB    <= b[DATA_W-1:0];
                        r_sign    <= a[DATA_W] ^ b[DATA_W];
                        r_accum   <= '0;
                        r_cnt     <= '0;
                        r_inReady <= 1'b0;
                        r_state   <= c_stBusy;
                    end else begin
                        // First edge out of reset raises in_ready
                        r_inReady <= 1'b1;
                    end
                end
                c_stBusy: begin
                    r_accum <= w_accNext;
                    if (w_lastBit) begin
                        r_prod     <= {r_sign & (|w_accNext), w_accNext};
                        r_prodQ    <= w_prodQ;
                        r_sat      <= w_sat;
                        r_outValid <= 1'b1;
                        r_state    <= c_stDone;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                c_stDone: begin
                    if (w_release) begin
                        r_outValid <= 1'b0;
                        r_inReady  <= 1'b1;
                        r_state    <= c_stIdle;
                    end
                end
                default: begin
                    r_outValid <= 1'b0;
                    r_inReady  <= 1'b1;
                    r_state    <= c_stIdle;
                end
            endcase
        end
    end

    assign in_ready  = r_inReady;
    assign out_valid = r_outValid;
    assign prod      = r_prod;
    assign prod_q    = r_prodQ;
    assign sat       = r_sat;

endmodule

`default_nettype wire

// File: tb/tb_sm_seq_multiplier.sv
//==============================================================================
// Module      : tb_sm_seq_multiplier
// Description : Directed self-checking bench for sm_seq_multiplier with
//               hand-computed products (DATA_W=10, FRAC_W=9).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_sm_seq_multiplier;

    localparam int DATA_W = 10;
    localparam int FRAC_W = 9;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W:0]   a;
    logic [DATA_W:0]   b;
    logic              out_valid;
    logic              out_ready;
    logic [2*DATA_W:0] prod;
    logic [DATA_W:0]   prod_q;
    logic              sat;

    int nCompared;
    int nMismatched;

    sm_seq_multiplier #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod      (prod),
        .prod_q    (prod_q),
        .sat       (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nCompared++;
        if (obs !== expv) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for in_ready, then present one operand pair for one edge
    task automatic accept(input string tag, input logic [DATA_W:0] va, input logic [DATA_W:0] vb);
        int n;
        n = 0;
        while (!in_ready && n < 30) begin
            tick();
            n++;
        end
        check({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, " in_ready after accept"}, 32'(in_ready), 32'd0);
    endtask

    // Count edges after accept until out_valid, bounded
    task automatic waitResult(input string tag);
        int edges;
        edges = 0;
        while (!out_valid && edges < 40) begin
            tick();
            edges++;
        end
        check({tag, " latency"}, 32'(edges), 32'd10);
    endtask

    task automatic runOp(input string tag, input logic [DATA_W:0] va, input logic [DATA_W:0] vb,
                         input logic [2*DATA_W:0] expProd, input logic [DATA_W:0] expQ,
                         input logic expSat);
        accept(tag, va, vb);
        waitResult(tag);
        check({tag, " prod"}, 32'(prod), 32'(expProd));
        check({tag, " prod_q"}, 32'(prod_q), 32'(expQ));
        check({tag, " sat"}, 32'(sat), 32'(expSat));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " out_valid after release"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready after release"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        rst_n       = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        a           = '0;
        b           = '0;

        // Reset state
        repeat (3) tick();
        check("reset in_ready", 32'(in_ready), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset prod", 32'(prod), 32'd0);
        check("reset prod_q", 32'(prod_q), 32'd0);
        check("reset sat", 32'(sat), 32'd0);
        rst_n = 1'b1;
        tick();
        check("in_ready first edge", 32'(in_ready), 32'd1);

        // 5 * -3 = -15, rescaled rounds to zero with sign 0
        runOp("small neg", 11'h005, 11'h403, 21'h10000F, 11'h000, 1'b0);
        // 1023 * -1023 = -1046529, saturates
        runOp("max sat", 11'h3FF, 11'h7FF, 21'h1FF801, 11'h7FF, 1'b1);
        // Negative zero times 7
        runOp("neg zero", 11'h400, 11'h007, 21'h000000, 11'h000, 1'b0);
        // Rounding tie 256 -> +1, and its negative mirror -> -1
        runOp("tie pos", 11'h010, 11'h010, 21'h000100, 11'h001, 1'b0);
        runOp("tie neg", 11'h410, 11'h010, 21'h100100, 11'h401, 1'b0);
        // -7 * 73 = -511 rounds to -1
        runOp("just below tie", 11'h407, 11'h049, 21'h1001FF, 11'h401, 1'b0);
        // 48 * 16 = 768 rounds to 2
        runOp("round up", 11'h030, 11'h010, 21'h000300, 11'h002, 1'b0);
        // 512 * 1023 = 523776 -> 1023 without saturation
        runOp("largest unsat", 11'h200, 11'h3FF, 21'h07FE00, 11'h3FF, 1'b0);
        // 513 * -1022 = -524286 -> rounds to 1024, clipped
        runOp("first sat", 11'h201, 11'h7FE, 21'h17FFFE, 11'h7FF, 1'b1);

        // Back-pressure: 512 * 384 = 196608 -> 384
        accept("stall", 11'h200, 11'h180);
        waitResult("stall");
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall out_valid", 32'(out_valid), 32'd1);
            check("stall in_ready", 32'(in_ready), 32'd0);
            check("stall prod", 32'(prod), 32'h030000);
            check("stall prod_q", 32'(prod_q), 32'h180);
            check("stall sat", 32'(sat), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("stall out_valid after release", 32'(out_valid), 32'd0);
        check("stall in_ready after release", 32'(in_ready), 32'd1);

        // Flush while cnt==4: back to IDLE, no result, held outputs untouched
        accept("flush", 11'h0FF, 11'h0FF);
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush in_ready", 32'(in_ready), 32'd1);
        check("flush out_valid", 32'(out_valid), 32'd0);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 15; i++) begin
                tick();
                if (out_valid) seen++;
            end
            check("flush no out_valid", 32'(seen), 32'd0);
        end
        check("flush prod held", 32'(prod), 32'h030000);

        // Flush wins over the output handshake in DONE
        accept("flush done", 11'h003, 11'h005);
        waitResult("flush done");
        flush     = 1'b1;
        out_ready = 1'b1;
        tick();
        flush     = 1'b0;
        out_ready = 1'b0;
        check("flush done out_valid", 32'(out_valid), 32'd0);
        check("flush done in_ready", 32'(in_ready), 32'd1);
        check("flush done prod", 32'(prod), 32'h00000F);

        // Asynchronous reset mid-BUSY clears everything without a clock edge
        accept("reset busy", 11'h123, 11'h456);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("async reset prod", 32'(prod), 32'd0);
        check("async reset prod_q", 32'(prod_q), 32'd0);
        check("async reset sat", 32'(sat), 32'd0);
        check("async reset out_valid", 32'(out_valid), 32'd0);
        check("async reset in_ready", 32'(in_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("after reset in_ready", 32'(in_ready), 32'd1);

        // Fresh operation after reset: -100 * -200 = 20000 -> 39
        runOp("after reset", 11'h464, 11'h4C8, 21'h004E20, 11'h027, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

`default_nettype wire
